// File: rtl/aes_pkg.sv
// Shared AES-128 constants, FSM state type and GF(2^8) column helpers
// used by the round sequencer and its MixColumns stage.
package aes_pkg;
  localparam int unsigned NR   = 10;
  localparam int unsigned NB   = 4;
  localparam logic [7:0]  POLY = 8'h1B;

  typedef enum logic [1:0] {IDLE, SB, AK} state_e;
  typedef logic [0:127] block_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? POLY : 8'h00);
  endfunction

  // Byte r+4c of the result comes from byte r+4((c+r)%4) of the input.
  function automatic block_t shift_rows(input block_t s);
    block_t t;
    t = '0;
    for (int unsigned c = 0; c < NB; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        t[8*(r+4*c) +: 8] = s[8*(r+4*((c+r)%4)) +: 8];
      end
    end
    return t;
  endfunction

  function automatic logic [0:31] mix_column(input logic [0:31] col);
    logic [7:0]  a [4];
    logic [0:31] res;
    res = '0;
    for (int unsigned j = 0; j < 4; j++) a[j] = col[8*j +: 8];
    for (int unsigned j = 0; j < 4; j++) begin
      res[8*j +: 8] = xtime(a[j]) ^ xtime(a[(j+1)%4]) ^ a[(j+1)%4]
                    ^ a[(j+2)%4] ^ a[(j+3)%4];
    end
    return res;
  endfunction
endpackage

// File: rtl/aes_mixcolumns.sv
// Combinational MixColumns over a full 128-bit column-major state.
module aes_mixcolumns
  import aes_pkg::*;
(
  input  logic [0:127] din,
  output logic [0:127] dout
);
  for (genvar c = 0; c < 4; c++) begin : g_col
    assign dout[32*c +: 32] = mix_column(din[32*c +: 32]);
  end
endmodule

// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 encryption sequencer: owns the state register, feeds an
// external registered SubBytes stage and applies ShiftRows/MixColumns/AddRoundKey.
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  output logic         ready,
  input  logic [0:127] plaintext,
  output logic [3:0]   rk_idx,
  input  logic [0:127] round_key,
  output logic [0:127] sb_in,
  input  logic [0:127] sb_out,
  output logic         done,
  output logic [0:127] ciphertext
);
  import aes_pkg::*;

  state_e       fsm;
  logic [3:0]   rnd;
  logic [0:127] sr;
  logic [0:127] mc;

  assign sr     = shift_rows(sb_out);
  assign rk_idx = rnd;

  aes_mixcolumns u_mix (
    .din  (sr),
    .dout (mc)
  );

  // sb_in is the state register itself, so SubBytes sees it with no extra stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm        <= IDLE;
      rnd        <= '0;
      sb_in      <= '0;
      ciphertext <= '0;
      done       <= 1'b0;
      ready      <= 1'b1;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            sb_in <= plaintext ^ round_key;
            rnd   <= 4'd1;
            ready <= 1'b0;
            fsm   <= SB;
          end
        end
        SB: fsm <= AK;
        AK: begin
          if (rnd == 4'(NR)) begin
            ciphertext <= sr ^ round_key;
            done       <= 1'b1;
            ready      <= 1'b1;
            rnd        <= '0;
            fsm        <= IDLE;
          end else begin
            sb_in <= mc ^ round_key;
            rnd   <= rnd + 4'd1;
            fsm   <= SB;
          end
        end
        default: begin
          fsm   <= IDLE;
          rnd   <= '0;
          ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: models the external SubBytes stage and key store
// and compares ciphertexts with a byte-level AES-128 reference.
module tb_aes_round_ctrl;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         ready;
  logic [127:0] plaintext = '0;
  logic [3:0]   rk_idx;
  logic [127:0] round_key;
  logic [127:0] sb_in;
  logic [127:0] sb_out = '0;
  logic         done;
  logic [127:0] ciphertext;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox  [256];
  logic [127:0] rkeys [11];

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CTC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CTZ = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ready      (ready),
    .plaintext  (plaintext),
    .rk_idx     (rk_idx),
    .round_key  (round_key),
    .sb_in      (sb_in),
    .sb_out     (sb_out),
    .done       (done),
    .ciphertext (ciphertext)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] sub128(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = sbox[v[127-8*i -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] key_of(input logic [127:0] key, input int rr);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*rr], w[4*rr+1], w[4*rr+2], w[4*rr+3]};
  endfunction

  function automatic logic [127:0] ref_enc(input logic [127:0] key, input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [127:0] k;
    logic [127:0] res;
    k = key_of(key, 0);
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) s[w+4*c] = t[w+4*((c+w)%4)];
      if (r < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int j = 0; j < 4; j++) t[j] = s[4*c+j];
          for (int j = 0; j < 4; j++)
            s[4*c+j] = gmul(t[j], 8'h02) ^ gmul(t[(j+1)%4], 8'h03) ^ t[(j+2)%4] ^ t[(j+3)%4];
        end
      end
      k = key_of(key, r);
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  // External registered SubBytes stage and combinational key store.
  always @(posedge clk) sb_out <= sub128(sb_in);
  assign round_key = (rk_idx <= 4'd10) ? rkeys[rk_idx] : '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Starts a block in the current cycle and waits (bounded) for done.
  task automatic run_block(input logic [127:0] key, input logic [127:0] pt,
                           input int busy_at, input bit hold_chk,
                           input logic [127:0] hold_val, input bit trace_chk,
                           output int lat, output logic [127:0] ct);
    int trace_bad = 0;
    int hold_bad = 0;
    for (int r = 0; r < 11; r++) rkeys[r] = key_of(key, r);
    plaintext = pt;
    start = 1'b1;
    step();
    start = 1'b0;
    plaintext = rnd128();
    lat = 0;
    while (!done && lat < 40) begin
      if (trace_chk && rk_idx !== 4'(lat / 2 + 1)) trace_bad++;
      if (hold_chk && ciphertext !== hold_val) hold_bad++;
      if (lat == busy_at) begin
        start = 1'b1;
        plaintext = rnd128();
      end else begin
        start = 1'b0;
      end
      step();
      lat++;
    end
    start = 1'b0;
    if (trace_chk) begin
      check("rk_idx_trace", 128'(trace_bad), 128'd0);
      check("rk_idx_done", 128'(rk_idx), 128'd0);
    end
    if (hold_chk) check("ct_hold", 128'(hold_bad), 128'd0);
    check("ready_at_done", 128'(ready), 128'd1);
    ct = ciphertext;
  endtask

  initial begin
    int           lat;
    int           done_seen;
    logic [127:0] ct;
    logic [127:0] k;
    logic [127:0] p;

    build_sbox();
    for (int r = 0; r < 11; r++) rkeys[r] = '0;
    #12;
    check("rst_ready", 128'(ready), 128'd1);
    check("rst_done", 128'(done), 128'd0);
    check("rst_ct", ciphertext, '0);
    check("rst_sb_in", sb_in, '0);
    check("rst_rk_idx", 128'(rk_idx), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    run_block(KB, PB, -1, 1'b0, '0, 1'b0, lat, ct);
    check("appb_latency", 128'(lat), 128'd20);
    check("appb_ct", ct, CTB);

    run_block(KC, PC, -1, 1'b1, CTB, 1'b1, lat, ct);
    check("b2b_latency", 128'(lat), 128'd20);
    check("appc1_ct", ct, CTC);

    run_block(KB, PB, 7, 1'b0, '0, 1'b0, lat, ct);
    check("busy_latency", 128'(lat), 128'd20);
    check("busy_ct", ct, CTB);

    // Abort a block mid-round with an asynchronous reset between clock edges.
    for (int r = 0; r < 11; r++) rkeys[r] = key_of(KC, r);
    plaintext = PC;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (11) step();
    #4;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 128'(ready), 128'd1);
    check("mid_rst_done", 128'(done), 128'd0);
    check("mid_rst_ct", ciphertext, '0);
    check("mid_rst_sb_in", sb_in, '0);
    check("mid_rst_rk_idx", 128'(rk_idx), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done) done_seen++;
    end
    check("no_done_after_rst", 128'(done_seen), 128'd0);

    run_block(KC, PC, -1, 1'b0, '0, 1'b0, lat, ct);
    check("post_rst_ct", ct, CTC);

    run_block('0, '0, -1, 1'b0, '0, 1'b0, lat, ct);
    check("zero_ct", ct, CTZ);

    for (int n = 0; n < 6; n++) begin
      k = rnd128();
      p = rnd128();
      run_block(k, p, (n % 2 == 1) ? int'($urandom_range(0, 18)) : -1,
                1'b0, '0, 1'b0, lat, ct);
      check("rand_latency", 128'(lat), 128'd20);
      check("rand_ct", ct, ref_enc(k, p));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
